cnn_image_loader: RTL
=====================

// Module: cnn_image_loader
// PURPOSE
// - Host-side front end for cnn_top: receives one MNIST sample as a byte stream.
//   Frame = 784 pixel bytes, then 1 label byte.
// - Assembles the flat image_data/label vectors, pulses start, waits for done,
//   then returns classification + label + match flag on a valid/ready result port.
// - Sits between the byte source (file loader / serial link) and cnn_top.
// PARAMETERS
// - NUM_PIXELS   784     pixel bytes per frame
// - PIX_W        8       bits per pixel
// - LABEL_W      4       label/classification width
// - TIMEOUT_CYC  200000  max cycles waiting for done; 0 disables the watchdog
// - CNT_W        16      width of statistics counters (MATCH_STATS_EN only)
// PORTS
// - clk             in   1                    clock, all logic on posedge
// - rst             in   1                    synchronous active-high reset
// - s_data          in   8                    input byte
// - s_valid         in   1                    s_data valid
// - s_ready         out  1                    loader accepts a byte this cycle
// - image_data      out  NUM_PIXELS*PIX_W     to cnn_top; pixel i at [i*PIX_W +: PIX_W]
// - label           out  LABEL_W              to cnn_top
// - start           out  1                    one-cycle pulse to cnn_top
// - done            in   1                    cnn_top completion
// - classification  in   LABEL_W              cnn_top result, sampled when done=1
// - r_class         out  LABEL_W              captured classification
// - r_label         out  LABEL_W              label of the same frame
// - r_match         out  1                    r_class == r_label
// - r_timeout       out  1                    watchdog expired; r_class = 0
// - r_valid         out  1                    result available
// - r_ready         in   1                    result consumed
// - busy            out  1                    high in every state except LOAD
// BEHAVIOUR
// - States: LOAD -> LABEL -> START -> WAIT -> REPORT -> LOAD.
// - Reset (any state): state=LOAD, pix_idx=0.
//   - image_data=0, label=0, start=0, r_valid=0, r_class=0, r_label=0,
//     r_match=0, r_timeout=0, busy=0, s_ready=1 in the next cycle.
//   - A partial frame is discarded.
// - LOAD: s_ready=1.
//   - On each s_valid&&s_ready, write s_data to pixel pix_idx and increment.
//   - At pix_idx==NUM_PIXELS-1 accept, then go to LABEL with pix_idx=0.
// - LABEL: s_ready=1.
//   - On accept, label<=s_data[LABEL_W-1:0]; upper bits are ignored.
//   - Go to START.
// - START: s_ready=0; start=1 for exactly one cycle; watchdog cleared; go to WAIT.
// - WAIT: s_ready=0; watchdog counts up.
//   - done=1: capture classification into r_class, r_match=(classification==label),
//     r_timeout=0, go to REPORT.
//   - Watchdog hits TIMEOUT_CYC (nonzero) before done: r_class=0, r_match=0,
//     r_timeout=1, go to REPORT.
//   - done and timeout in the same cycle: done wins.
// - REPORT: r_valid=1; outputs held stable until r_valid&&r_ready.
//   - That cycle: r_valid drops next cycle and state returns to LOAD.
// - done is ignored outside WAIT.
//   - A late done after a timeout must not alter results or state.
// - image_data/label change only in LOAD/LABEL; stable from START through REPORT.
// - Latency: last label byte accepted at cycle N -> start=1 at N+1 -> WAIT from N+2.
//   - done at cycle D -> r_valid=1 at D+1.
// - s_valid while s_ready=0 is not consumed; the source holds data (no drop, no overflow).
// CONFIGURATION
// - MATCH_STATS_EN defined: adds ports img_count, hit_count
//   (out, CNT_W each, reset 0).
//   - img_count increments at each REPORT handshake.
//   - hit_count increments at each REPORT handshake with r_match=1.
//   - Both saturate at all-ones.
// - MATCH_STATS_EN undefined: ports and counters absent; all other behaviour
//   identical.
// TESTING
// - Frame: pixels i&8'hFF, label byte 8'h07; model done=1 with classification=7
//   after 50 cycles.
//   -> image_data[i*8+:8]==i&255, label=7, single start pulse, r_class=7, r_match=1.
// - Same frame, classification=3 -> r_match=0, r_label=7; img_count=2, hit_count=1
//   (stats build).
// - s_valid toggling randomly, r_ready held low 20 cycles.
//   -> all 785 bytes captured in order; r_valid and outputs held stable; no new
//      byte accepted until handshake.
// - TIMEOUT_CYC=100, done never asserted.
//   -> r_timeout=1, r_class=0 at cycle 101 after WAIT entry.
//   - A done pulse afterwards is ignored.
// - rst asserted after 400 pixel bytes.
//   -> next cycle outputs at reset values; a fresh full frame then completes
//      normally.
// - Label byte 8'hF5 -> label=4'h5; done and timeout coincide -> r_timeout=0,
//   classification captured.

Source files
------------

// File: rtl/cnn_image_loader_if.sv
// rtl/cnn_image_loader_if.sv - byte stream, cnn_top and result signals of cnn_image_loader
interface cnn_image_loader_if #(
  parameter int NUM_PIXELS = 784,
  parameter int PIX_W      = 8,
  parameter int LABEL_W    = 4
);
  logic [7:0]                  s_data;
  logic                        s_valid;
  logic                        s_ready;
  logic [NUM_PIXELS*PIX_W-1:0] image_data;
  logic [LABEL_W-1:0]          label;
  logic                        start;
  logic                        done;
  logic [LABEL_W-1:0]          classification;
  logic [LABEL_W-1:0]          r_class;
  logic [LABEL_W-1:0]          r_label;
  logic                        r_match;
  logic                        r_timeout;
  logic                        r_valid;
  logic                        r_ready;
  logic                        busy;

  // master is the loader; slave is the byte source, cnn_top and result consumer
  modport master (
    input  s_data, s_valid, done, classification, r_ready,
    output s_ready, image_data, label, start, r_class, r_label, r_match,
           r_timeout, r_valid, busy
  );

  modport slave (
    output s_data, s_valid, done, classification, r_ready,
    input  s_ready, image_data, label, start, r_class, r_label, r_match,
           r_timeout, r_valid, busy
  );
endinterface

// File: rtl/cnn_image_loader.sv
// rtl/cnn_image_loader.sv - MNIST byte-stream loader, cnn_top launcher and result reporter
// Define MATCH_STATS_EN to add saturating img_count/hit_count statistics ports.
module cnn_image_loader #(
  parameter int NUM_PIXELS  = 784,
  parameter int PIX_W       = 8,
  parameter int LABEL_W     = 4,
  parameter int TIMEOUT_CYC = 200000,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  cnn_image_loader_if.master bus
`ifdef MATCH_STATS_EN
  ,
  output logic [CNT_W-1:0]   img_count,
  output logic [CNT_W-1:0]   hit_count
`endif
);

  localparam int IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int WD_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_LOAD,
    S_LABEL,
    S_START,
    S_WAIT,
    S_REPORT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] pix_idx;
  logic [WD_W-1:0]  wdog;
  logic             accept;
  logic             wd_expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bus.s_ready = 1'b0;
    bus.start   = 1'b0;
    bus.r_valid = 1'b0;
    bus.busy    = 1'b1;
    wd_expired  = (TIMEOUT_CYC != 0) && (wdog == WD_LIMIT);
    case (state)
      S_LOAD: begin
        bus.s_ready = 1'b1;
        bus.busy    = 1'b0;
        if (bus.s_valid && (pix_idx == LAST_IDX)) begin
          state_nxt = S_LABEL;
        end
      end
      S_LABEL: begin
        bus.s_ready = 1'b1;
        if (bus.s_valid) begin
          state_nxt = S_START;
        end
      end
      S_START: begin
        bus.start = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.done || wd_expired) begin
          state_nxt = S_REPORT;
        end
      end
      S_REPORT: begin
        bus.r_valid = 1'b1;
        if (bus.r_ready) begin
          state_nxt = S_LOAD;
        end
      end
      default: begin
        state_nxt = S_LOAD;
      end
    endcase
  end

  assign accept = bus.s_valid && bus.s_ready;

  // Frame assembly, watchdog and result capture; done outside WAIT never reaches here
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_idx        <= '0;
      wdog           <= '0;
      bus.image_data <= '0;
      bus.label      <= '0;
      bus.r_class    <= '0;
      bus.r_label    <= '0;
      bus.r_match    <= 1'b0;
      bus.r_timeout  <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (accept) begin
            bus.image_data[pix_idx*PIX_W +: PIX_W] <= bus.s_data[PIX_W-1:0];
            pix_idx <= (pix_idx == LAST_IDX) ? '0 : pix_idx + 1'b1;
          end
        end
        S_LABEL: begin
          if (accept) begin
            bus.label <= bus.s_data[LABEL_W-1:0];
          end
        end
        S_START: begin
          wdog <= '0;
        end
        S_WAIT: begin
          if (bus.done) begin
            bus.r_class   <= bus.classification;
            bus.r_label   <= bus.label;
            bus.r_match   <= (bus.classification == bus.label);
            bus.r_timeout <= 1'b0;
          end else if (wd_expired) begin
            bus.r_class   <= '0;
            bus.r_label   <= bus.label;
            bus.r_match   <= 1'b0;
            bus.r_timeout <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MATCH_STATS_EN
  logic res_take;
  assign res_take = bus.r_valid && bus.r_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      img_count <= '0;
      hit_count <= '0;
    end else if (res_take) begin
      if (img_count != '1) begin
        img_count <= img_count + 1'b1;
      end
      if (bus.r_match && (hit_count != '1)) begin
        hit_count <= hit_count + 1'b1;
      end
    end
  end
`endif

endmodule
